// File: rtl/sync_mac_accumulator_pkg.sv
// Shared constants and width helper for the synchronous MAC wrappers.
package mac_pkg;

    localparam int MUL_LATENCY = 2;

    // Exact width of a sum of acc_count unsigned products of two mul_width operands.
    function automatic int accw(input int mul_width, input int acc_count);
        return 2 * mul_width + $clog2(acc_count);
    endfunction

endpackage

// File: rtl/sync_mac_accumulator_delay.sv
// Shift register of valid tags; tap gi is the input delayed by gi+1 cycles.
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    output logic [DEPTH-1:0] taps_o
);

    logic [DEPTH-1:0] vld_q;

    if (DEPTH < 1) begin : g_depth_check
        $error("valid_delay_line: DEPTH must be >= 1");
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic stage_d;
        if (gi == 0) begin : g_head
            assign stage_d = valid_i;
        end else begin : g_tail
            assign stage_d = vld_q[gi-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q[gi] <= 1'b0;
            end else begin
                vld_q[gi] <= stage_d;
            end
        end
    end

    assign taps_o = vld_q;

endmodule

// File: rtl/sync_mac_accumulator.sv
// Handshaked MAC front/back end around an external 2-cycle multiplier:
// tags accepted pairs, sums returning products into frames, buffers one frame sum.
module sync_mac_accumulator
    import mac_pkg::*;
#(
    parameter int MUL_WIDTH = 4,
    parameter int ACC_COUNT = 4,
    parameter int ACC_WIDTH = accw(MUL_WIDTH, ACC_COUNT)
) (
    input  logic                   accClock,
    input  logic                   resetN,
    input  logic                   opValid,
    output logic                   opReady,
    input  logic [MUL_WIDTH-1:0]   opA,
    input  logic [MUL_WIDTH-1:0]   opB,
    output logic [MUL_WIDTH-1:0]   mulA,
    output logic [MUL_WIDTH-1:0]   mulB,
    input  logic [2*MUL_WIDTH-1:0] mulProduct,
    output logic                   resValid,
    input  logic                   resReady,
    output logic [ACC_WIDTH-1:0]   resSum,
    output logic                   frameBusy
);

    localparam int CNT_W = $clog2(ACC_COUNT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_COUNT - 1);

    // Fewer than 3 products per frame could complete a frame while the buffer is stalled.
    if (ACC_COUNT < 3) begin : g_acc_count_check
        $error("sync_mac_accumulator: ACC_COUNT must be >= 3");
    end

    logic                   accept;
    logic                   land;
    logic                   complete;
    logic [MUL_LATENCY-1:0] vld;
    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]   acc_sum;

    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       land_cnt_q, land_cnt_d;
    logic [ACC_WIDTH-1:0]   res_sum_q, res_sum_d;
    logic                   res_valid_q, res_valid_d;

    assign opReady = !(res_valid_q && !resReady);
    assign accept  = opValid && opReady;
    assign mulA    = opA;
    assign mulB    = opB;

    valid_delay_line #(
        .DEPTH   (MUL_LATENCY)
    ) u_vld (
        .clk     (accClock),
        .rst_n   (resetN),
        .valid_i (accept),
        .taps_o  (vld)
    );

    assign land     = vld[MUL_LATENCY-1];
    assign complete = land && (land_cnt_q == LAST_CNT);
    assign prod_ext = ACC_WIDTH'(mulProduct);
    assign acc_sum  = acc_q + prod_ext;

    always_comb begin
        acc_d       = acc_q;
        land_cnt_d  = land_cnt_q;
        res_sum_d   = res_sum_q;
        res_valid_d = res_valid_q;

        if (res_valid_q && resReady) begin
            res_valid_d = 1'b0;
        end

        if (complete) begin
            res_sum_d   = acc_sum;
            res_valid_d = 1'b1;
            acc_d       = '0;
            land_cnt_d  = '0;
        end else if (land) begin
            acc_d       = acc_sum;
            land_cnt_d  = land_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge accClock or negedge resetN) begin
        if (!resetN) begin
            acc_q       <= '0;
            land_cnt_q  <= '0;
            res_sum_q   <= '0;
            res_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            land_cnt_q  <= land_cnt_d;
            res_sum_q   <= res_sum_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign resValid  = res_valid_q;
    assign resSum    = res_sum_q;
    assign frameBusy = (land_cnt_q != '0) || (|vld);

endmodule

// File: tb/tb_sync_mac_accumulator.sv
// Scoreboard bench: two accumulator builds, each fed by a behavioural 2-cycle multiplier.
module tb_sync_mac_accumulator;

    logic        clk = 1'b0;
    logic        resetN;

    // Default build: MUL_WIDTH=4, ACC_COUNT=4, ACC_WIDTH=10
    logic        opValid, opReady, resValid, resReady, frameBusy;
    logic [3:0]  opA, opB, mulA, mulB;
    logic [7:0]  mulProduct, p1_q, p2_q;
    logic [9:0]  resSum;

    // Wide build: MUL_WIDTH=8, ACC_COUNT=3, ACC_WIDTH=18
    logic        opValid8, opReady8, resValid8, resReady8, frameBusy8;
    logic [7:0]  opA8, opB8, mulA8, mulB8;
    logic [15:0] mulProduct8, p1w_q, p2w_q;
    logic [17:0] resSum8;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int exp8_q[$];

    always #5 clk = ~clk;

    sync_mac_accumulator dut (
        .accClock   (clk),
        .resetN     (resetN),
        .opValid    (opValid),
        .opReady    (opReady),
        .opA        (opA),
        .opB        (opB),
        .mulA       (mulA),
        .mulB       (mulB),
        .mulProduct (mulProduct),
        .resValid   (resValid),
        .resReady   (resReady),
        .resSum     (resSum),
        .frameBusy  (frameBusy)
    );

    sync_mac_accumulator #(
        .MUL_WIDTH (8),
        .ACC_COUNT (3)
    ) dut8 (
        .accClock   (clk),
        .resetN     (resetN),
        .opValid    (opValid8),
        .opReady    (opReady8),
        .opA        (opA8),
        .opB        (opB8),
        .mulA       (mulA8),
        .mulB       (mulB8),
        .mulProduct (mulProduct8),
        .resValid   (resValid8),
        .resReady   (resReady8),
        .resSum     (resSum8),
        .frameBusy  (frameBusy8)
    );

    // Behavioural multipliers: product of the cycle-k operands appears in cycle k+2.
    always_ff @(posedge clk) begin
        p1_q  <= mulA * mulB;
        p2_q  <= p1_q;
        p1w_q <= mulA8 * mulB8;
        p2w_q <= p1w_q;
    end
    assign mulProduct  = p2_q;
    assign mulProduct8 = p2w_q;

    function automatic void check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", name, act, $time);
        end
    endfunction

    // Monitors: pop the scoreboard whenever a result is handed off.
    always @(negedge clk) begin
        if (resetN && resValid && resReady) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got %0d, expected no result", resSum);
            end else begin
                check("resSum", resSum, exp_q.pop_front());
            end
        end
        if (resetN && resValid8 && resReady8) begin
            if (exp8_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result8: got %0d, expected no result", resSum8);
            end else begin
                check("resSum8", resSum8, exp8_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int g = 0;
        opA = a;
        opB = b;
        opValid = 1'b1;
        while (!opReady && g < 50) begin
            step();
            g++;
        end
        if (!opReady) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: opReady got 0, expected 1 within 50 cycles");
        end
        step();
        opValid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b);
        int g = 0;
        opA8 = a;
        opB8 = b;
        opValid8 = 1'b1;
        while (!opReady8 && g < 50) begin
            step();
            g++;
        end
        if (!opReady8) begin
            n_vec++;
            n_err++;
            $display("FAIL send8_timeout: opReady8 got 0, expected 1 within 50 cycles");
        end
        step();
        opValid8 = 1'b0;
    endtask

    task automatic idle(input int n, input bit chk_busy);
        opValid = 1'b0;
        repeat (n) begin
            if (chk_busy) check("frameBusy_bubble", frameBusy, 1);
            step();
        end
    endtask

    task automatic drain();
        int g = 0;
        opValid  = 1'b0;
        opValid8 = 1'b0;
        while ((exp_q.size() != 0 || exp8_q.size() != 0) && g < 40) begin
            step();
            g++;
        end
        if (g >= 40) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0",
                     exp_q.size() + exp8_q.size());
        end
        check("frameBusy_idle", frameBusy, 0);
    endtask

    initial begin
        resetN    = 1'b0;
        opValid   = 1'b0;
        opA       = '0;
        opB       = '0;
        resReady  = 1'b1;
        opValid8  = 1'b0;
        opA8      = '0;
        opB8      = '0;
        resReady8 = 1'b1;

        repeat (3) step();
        check("reset_resValid", resValid, 0);
        check("reset_frameBusy", frameBusy, 0);
        check("reset_opReady", opReady, 1);
        check("reset_resSum", resSum, 0);
        resetN = 1'b1;
        step();

        // Frame 1: 15+14+225+1 = 255, resValid pulses in cycles k+3 only
        send(4'd3, 4'd5);
        send(4'd2, 4'd7);
        send(4'd15, 4'd15);
        send(4'd1, 4'd1);
        exp_q.push_back(255);
        check("lat_k1_resValid", resValid, 0);
        step();
        check("lat_k2_resValid", resValid, 0);
        step();
        check("lat_k3_resValid", resValid, 1);
        step();
        check("lat_k4_resValid", resValid, 0);
        drain();

        // Max frame: 4 * 225 = 900 fits the 10-bit result
        repeat (4) send(4'd15, 4'd15);
        exp_q.push_back(900);
        drain();

        // Same frame as frame 1 with bubbles between pairs
        send(4'd3, 4'd5);
        idle(2, 1'b1);
        send(4'd2, 4'd7);
        idle(3, 1'b1);
        send(4'd15, 4'd15);
        idle(1, 1'b1);
        send(4'd1, 4'd1);
        exp_q.push_back(255);
        drain();

        // Back-to-back frames with a 5-cycle downstream stall after the first result
        resReady = 1'b0;
        send(4'd3, 4'd5);
        send(4'd2, 4'd7);
        send(4'd15, 4'd15);
        send(4'd1, 4'd1);
        exp_q.push_back(255);
        send(4'd1, 4'd1);
        send(4'd1, 4'd1);
        opA = 4'd1;
        opB = 4'd1;
        opValid = 1'b1;
        repeat (5) begin
            check("stall_opReady", opReady, 0);
            check("stall_resValid", resValid, 1);
            check("stall_resSum", resSum, 255);
            step();
        end
        resReady = 1'b1;
        step();
        send(4'd1, 4'd1);
        exp_q.push_back(4);
        drain();

        // Abort a frame with reset after two accepts; resSum (4) must clear
        send(4'd9, 4'd9);
        send(4'd9, 4'd9);
        resetN = 1'b0;
        #1;
        check("midreset_frameBusy", frameBusy, 0);
        check("midreset_resValid", resValid, 0);
        check("midreset_opReady", opReady, 1);
        check("midreset_resSum", resSum, 0);
        step();
        step();
        resetN = 1'b1;
        step();
        repeat (4) send(4'd2, 4'd2);
        exp_q.push_back(16);
        drain();

        // Wide build: 3 * 65025 = 195075 in 18 bits
        send8(8'd255, 8'd255);
        send8(8'd255, 8'd255);
        send8(8'd255, 8'd255);
        exp8_q.push_back(195075);
        drain();
        check("frameBusy8_idle", frameBusy8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
